// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The master side issues operands and accepts results; the slave side is the adder.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Carry-pipelined adder/subtractor: each stage adds one CHUNK-bit slice and hands
// its carry, the remaining operand bits and the finished sum slices to the next stage.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int NREG  = (STAGES > 1) ? STAGES - 1 : 1;

    logic              advance;
    logic [STAGES-1:0] vld_q;

    logic [WIDTH-1:0]  a_q [NREG];
    logic [WIDTH-1:0]  b_q [NREG];
    logic [WIDTH-1:0]  s_q [NREG];
    logic              c_q [NREG];

    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_src [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic              c_src [STAGES];
    logic              c_nxt [STAGES];

    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;
    logic              ovf_nxt;

    function automatic logic [CHUNK:0] add_chunk(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + (CHUNK+1)'(c);
    endfunction

    function automatic logic [WIDTH-1:0] place_chunk(
        input logic [WIDTH-1:0] s,
        input logic [CHUNK-1:0] slice,
        input int               k
    );
        logic [WIDTH-1:0] r;
        r = s;
        r[k*CHUNK +: CHUNK] = slice;
        return r;
    endfunction

    // Global stall: the whole pipe moves only when the output slot is free or drained.
    assign advance       = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0] part;

        if (k == 0) begin : g_first
            // Subtraction folds into an add of ~b with the carry-in inverted.
            assign a_src[k] = bus.a;
            assign b_src[k] = bus.b ^ {WIDTH{bus.sub}};
            assign s_src[k] = '0;
            assign c_src[k] = bus.cin ^ bus.sub;
        end else begin : g_next
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign s_src[k] = s_q[k-1];
            assign c_src[k] = c_q[k-1];
        end

        assign part     = add_chunk(a_src[k][k*CHUNK +: CHUNK], b_src[k][k*CHUNK +: CHUNK], c_src[k]);
        assign c_nxt[k] = part[CHUNK];
        assign s_nxt[k] = place_chunk(s_src[k], part[CHUNK-1:0], k);
    end

    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign ovf_nxt = (a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1] ^ s_nxt[STAGES-1][WIDTH-1])
                     ^ c_nxt[STAGES-1];

    // Stage boundaries 0..STAGES-2: skew registers, contents meaningful only when valid.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_nxt[k];
                c_q[k] <= c_nxt[k];
            end
        end
    end

    // Final boundary: valid chain and registered result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            vld_q[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            sum_q  <= s_nxt[STAGES-1];
            cout_q <= c_nxt[STAGES-1];
            ovf_q  <= ovf_nxt;
            zero_q <= (s_nxt[STAGES-1] == '0);
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: drivers push expected results at acceptance,
// a monitor pops and compares whenever a result is handed off downstream.
module tb_pipelined_addsub;
    localparam int W = 16;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n;

    pipelined_addsub_if #(.WIDTH(W)) bus ();

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   rnd_done;

    bit           hold_v = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout, hold_ovf, hold_zero;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic report(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Reference: whole-word integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint ua, ub, sa, sbv, ci, u, s, lim;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ci  = cin ? 1 : 0;
        lim = longint'(1) << (W - 1);
        if (!sub) begin
            u      = ua + ub + ci;
            s      = sa + sbv + ci;
            e.cout = (u >= (longint'(1) << W));
        end else begin
            u      = ua - ub - ci;
            s      = sa - sbv - ci;
            e.cout = (u >= 0);
        end
        e.sum  = u[W-1:0];
        e.ovf  = (s >= lim) || (s < -lim);
        e.zero = (e.sum == '0);
        e.acc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input exp_t e);
        bit done = 1'b0;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        for (int w = 0; w < 64 && !done; w++) begin
            #4;
            if (bus.in_ready) begin
                e.acc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) report(1'b0, "accept_timeout", "got in_ready=0 for 64 cycles, expected acceptance");
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input bit lat);
        exp_t e;
        e     = model(a, b, cin, sub);
        e.lat = lat;
        drive(a, b, cin, sub, e);
    endtask

    task automatic send_k(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] s, input logic co, input logic ov);
        exp_t e;
        e.sum  = s;
        e.cout = co;
        e.ovf  = ov;
        e.zero = (s == '0);
        e.acc  = 0;
        e.lat  = 1'b1;
        drive(a, b, cin, sub, e);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
        report(sb.size() == 0, "drain", $sformatf("got %0d results outstanding, expected 0", sb.size()));
        repeat (2) @(negedge clk);
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                report(bus.in_ready === (!bus.out_valid || bus.out_ready), "in_ready",
                       $sformatf("got in_ready=%b, expected %b", bus.in_ready, !bus.out_valid || bus.out_ready));
                if (hold_v) begin
                    report(bus.out_valid === 1'b1 && bus.sum === hold_sum && bus.cout === hold_cout &&
                           bus.ovf === hold_ovf && bus.zero === hold_zero, "hold",
                           $sformatf("got v=%b sum=%h c=%b o=%b z=%b, expected v=1 sum=%h c=%b o=%b z=%b",
                                     bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero,
                                     hold_sum, hold_cout, hold_ovf, hold_zero));
                end
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        report(1'b0, "unexpected", $sformatf("got result sum=%h, expected no result", bus.sum));
                    end else begin
                        e = sb.pop_front();
                        report(bus.sum === e.sum && bus.cout === e.cout && bus.ovf === e.ovf && bus.zero === e.zero,
                               "result",
                               $sformatf("got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                                         bus.sum, bus.cout, bus.ovf, bus.zero, e.sum, e.cout, e.ovf, e.zero));
                        if (e.lat) report(cyc - e.acc == S, "latency",
                                          $sformatf("got %0d cycles, expected %0d", cyc - e.acc, S));
                    end
                end
                hold_v    = bus.out_valid && !bus.out_ready;
                hold_sum  = bus.sum;
                hold_cout = bus.cout;
                hold_ovf  = bus.ovf;
                hold_zero = bus.zero;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        report(bus.out_valid === 1'b0, "rst_out_valid", $sformatf("got %b, expected 0", bus.out_valid));
        report(bus.sum === '0, "rst_sum", $sformatf("got %h, expected 0000", bus.sum));
        report(bus.cout === 1'b0, "rst_cout", $sformatf("got %b, expected 0", bus.cout));
        report(bus.ovf === 1'b0, "rst_ovf", $sformatf("got %b, expected 0", bus.ovf));
        report(bus.zero === 1'b0, "rst_zero", $sformatf("got %b, expected 0", bus.zero));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #4;
        report(bus.in_ready === 1'b1, "rst_in_ready", $sformatf("got %b, expected 1", bus.in_ready));
        @(negedge clk);

        // Directed carry / overflow / borrow cases
        send_k(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_k(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_k(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_k(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send_k(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        drain();

        // Back-to-back random stream with a 3-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #4;
                    report(bus.in_ready === 1'b0 && bus.out_valid === 1'b1, "stall",
                           $sformatf("got in_ready=%b out_valid=%b, expected 0 and 1", bus.in_ready, bus.out_valid));
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Alternating add/sub with carry-in set, one result per cycle
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send_k(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
            else            send_k(16'h1234, 16'h0FFF, 1'b1, 1'b1, 16'h0234, 1'b1, 1'b0);
        end
        drain();

        // Reset with a parked result and three more in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(W'($urandom) | 16'h0100, W'($urandom), 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        report(bus.out_valid === 1'b0, "mid_rst_valid", $sformatf("got %b, expected 0", bus.out_valid));
        report(bus.sum === '0 && bus.cout === 1'b0 && bus.ovf === 1'b0 && bus.zero === 1'b0, "mid_rst_flags",
               $sformatf("got sum=%h c=%b o=%b z=%b, expected all 0", bus.sum, bus.cout, bus.ovf, bus.zero));
        sb.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #4;
            if (i == 0) report(bus.in_ready === 1'b1, "post_rst_ready", $sformatf("got %b, expected 1", bus.in_ready));
            report(bus.out_valid === 1'b0, "stale", $sformatf("got out_valid=%b in cycle %0d, expected 0", bus.out_valid, i));
            @(negedge clk);
        end

        // Random traffic with random gaps and random back-pressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(negedge clk);
                    end
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                end
                bus.in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.out_ready = ($urandom_range(2) != 0);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter STAGES, default 4, the number of pipeline stages (1 <= STAGES <= WIDTH, WIDTH % STAGES == 0); CHUNK = WIDTH/STAGES bits are added per stage.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the operand set is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts an operand set this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH, the operands (two's complement or unsigned).
REQ-008 The block SHALL have port cin, input, 1, carry-in (add) or borrow-in (subtract).
REQ-009 The block SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-010 The block SHALL have port out_valid, output, 1, meaning result outputs are valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-012 The block SHALL have port sum, output, WIDTH, the result.
REQ-013 The block SHALL have port cout, output, 1, carry-out (add) or not-borrow (subtract).
REQ-014 The block SHALL have port ovf, output, 1, two's-complement signed overflow.
REQ-015 The block SHALL have port zero, output, 1, asserted when sum == 0.

Function
REQ-016 Add SHALL compute {cout,sum} = a + b + cin; subtract SHALL compute {cout,sum} = a + ~b + ~cin, i.e. a - b - cin with cout = 1 when no borrow occurs.
REQ-017 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] with the carry registered from stage k-1; the effective stage-0 carry SHALL be cin ^ sub.
REQ-018 Operand bits not yet consumed and completed sum chunks SHALL be carried forward in skew registers, so that each transaction travels as one unit.
REQ-019 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, computed in the final stage.
REQ-020 Latency SHALL be exactly STAGES cycles from acceptance (in_valid & in_ready) to out_valid, with no stalls.
REQ-021 Throughput SHALL be one transaction per cycle when out_ready is held at 1.
REQ-022 advance SHALL be defined as !out_valid | out_ready; in_ready SHALL equal advance, and every stage register and valid bit SHALL update only when advance is 1 (global stall).
REQ-023 While out_valid=1 and out_ready=0, sum, cout, ovf, zero and out_valid SHALL hold stable.
REQ-024 A bubble (in_valid=0 on an advance cycle) SHALL propagate as an invalid stage; the datapath contents of invalid stages are don't-care.
REQ-025 sub and cin SHALL be sampled only at acceptance, so per-transaction mode changes on consecutive cycles are legal.
REQ-026 Simultaneous output handshake and input acceptance in one cycle SHALL both complete with no loss or duplication.

Reset
REQ-027 Asserting rst_n=0 SHALL asynchronously clear all stage valid bits and set out_valid=0, sum=0, cout=0, ovf=0, zero=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight transactions; no result SHALL emerge after reset release.
REQ-029 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.

Verification (WIDTH=16, STAGES=4)
REQ-030 Test 1: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> exactly 4 cycles later sum=0x0000, cout=1, ovf=0, zero=1.
REQ-031 Test 2: a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1, zero=0.
REQ-032 Test 3: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 Test 4: stream 8 random back-to-back transactions with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 8 results in order and matching the reference model.
REQ-034 Test 5: assert rst_n=0 with 3 transactions in flight -> out_valid=0 immediately; after release, no stale result appears within 8 cycles.
REQ-035 Test 6: alternating add/sub with cin=1 every cycle, for a=0x1234, b=0x0FFF -> results alternate 0x2234 and 0x0234, with one result per cycle.
